line_serializer: RTL and testbench

Read-side counterpart to the cache data array's word-granular write port. It accepts a line-evict/fill-forward request, and reads the full line through the array's line-wide port B. It then streams the line out one word per handshake in wrap-around order, starting at a requested critical word. It sits between the cache data array and the memory-side writeback / core-side refill word bus.

---
 rtl/line_serializer_if.sv | 34 +++
 rtl/line_serializer.sv | 109 ++++++++++
 tb/tb_line_serializer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_serializer_if.sv
// Handshake and array-port bundle for line_serializer: request in, port-B read, word stream out.
// The master modport is the serializer's view; slave is the surrounding parent/consumer.
interface line_serializer_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int INDEX_WIDTH = 9,
  parameter int WORD_BITS   = 3
);
  localparam int SW = DATA_WIDTH >> WORD_BITS;

  logic                   req_valid;
  logic                   req_ready;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_BITS-1:0]   req_word;

  logic                   rd_en;
  logic [INDEX_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]  rd_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [SW-1:0]          out_data;
  logic [WORD_BITS-1:0]   out_word;
  logic                   out_last;

  modport master (
    input  req_valid, req_index, req_word, rd_data, out_ready,
    output req_ready, rd_en, rd_addr, out_valid, out_data, out_word, out_last
  );

  modport slave (
    output req_valid, req_index, req_word, rd_data, out_ready,
    input  req_ready, rd_en, rd_addr, out_valid, out_data, out_word, out_last
  );
endinterface

// File: rtl/line_serializer.sv
// Reads a full cache line through the array's port B and streams it out one word per
// handshake in wrap-around order, starting from the requested critical word.
module line_serializer #(
  parameter int DATA_WIDTH  = 256,
  parameter int INDEX_WIDTH = 9,
  parameter int WORD_BITS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  line_serializer_if.master bus
);
  localparam int WORDS = 2 ** WORD_BITS;
  localparam int SW    = DATA_WIDTH / WORDS;
  localparam logic [WORD_BITS:0] LAST_COUNT = (WORD_BITS + 1)'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    SEND
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [INDEX_WIDTH-1:0]    idx;
  logic [WORD_BITS-1:0]      start;
  logic [WORD_BITS-1:0]      ptr;
  logic [WORD_BITS:0]        count;
  logic [WORDS-1:0][SW-1:0]  line_buf;
  logic                      last;

  assign last = (state == SEND) && (count == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = READ;
      end
      READ: begin
        bus.rd_en  = 1'b1;
        state_next = CAPT;
      end
      CAPT: state_next = SEND;
      SEND: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; the buffer only ever loads in CAPT, so later array writes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      start    <= '0;
      ptr      <= '0;
      count    <= '0;
      // NOTE: the line buffer is reset too, because out_data must read as zero straight out of reset.
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            idx   <= bus.req_index;
            start <= bus.req_word;
            ptr   <= bus.req_word;
            count <= '0;
          end
        end
        CAPT: begin
          line_buf <= bus.rd_data;
          count    <= '0;
        end
        SEND: begin
          if (bus.out_ready) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_addr  = idx;
  assign bus.out_word = ptr;
  assign bus.out_data = line_buf[ptr];
  assign bus.out_last = last;

  // ptr always sits exactly count words past the critical word.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == SEND) |-> (ptr == start + count[WORD_BITS-1:0]));

endmodule

// File: tb/tb_line_serializer.sv
// Randomised scoreboard bench for line_serializer: a line-level model predicts each word stream
// from an array snapshot taken at request acceptance; a negedge monitor compares and checks timing.
module tb_line_serializer;
  localparam int DW = 256;
  localparam int IW = 9;
  localparam int WB = 3;
  localparam int NW = 8;
  localparam int SW = 32;

  typedef struct {
    logic [SW-1:0] data;
    logic [WB-1:0] word;
    logic          last;
  } exp_t;

  typedef struct {
    int idx;
    int cyc;
  } acc_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   words_seen;
  logic bp;

  logic [DW-1:0] mem [512];

  exp_t sb[$];
  acc_t rd_q[$];
  int   ov_q[$];

  logic          prev_valid;
  logic          prev_ready;
  logic          prev_last;
  logic [WB-1:0] prev_word;
  logic [SW-1:0] prev_data;
  logic          expect_idle;

  line_serializer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB)) bus ();

  line_serializer #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array port B: registered read, data valid one cycle after the address cycle.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready: always 1, or a coin flip per cycle while back-pressure is enabled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard.
  initial begin : monitor
    logic [DW-1:0] line;
    exp_t          e;
    acc_t          a;
    int            w;
    int            c;
    prev_valid  = 1'b0;
    prev_ready  = 1'b0;
    prev_last   = 1'b0;
    prev_word   = '0;
    prev_data   = '0;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        rd_q.delete();
        ov_q.delete();
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          check("ready_after_last", {bus.req_ready, bus.out_valid}, 2'b10);
          expect_idle = 1'b0;
        end
        if (prev_valid && !prev_ready)
          check("stall_hold", {bus.out_valid, bus.out_last, bus.out_word, bus.out_data},
                {1'b1, prev_last, prev_word, prev_data});
        if (bus.out_valid && !prev_valid) begin
          check("first_word_expected", ov_q.size() > 0, 1);
          if (ov_q.size() > 0) begin
            c = ov_q.pop_front();
            check("first_word_cycle", cyc, c + 3);
          end
        end
        if (bus.rd_en) begin
          check("rd_expected", rd_q.size() > 0, 1);
          if (rd_q.size() > 0) begin
            a = rd_q.pop_front();
            check("rd_addr", bus.rd_addr, a.idx);
            check("rd_cycle", cyc, a.cyc + 1);
          end
        end
        if (bus.req_valid && bus.req_ready) begin
          line = mem[bus.req_index];
          for (int k = 0; k < NW; k++) begin
            w      = (int'(bus.req_word) + k) % NW;
            e.data = line[SW*w +: SW];
            e.word = WB'(w);
            e.last = (k == NW - 1);
            sb.push_back(e);
          end
          a.idx = int'(bus.req_index);
          a.cyc = cyc;
          rd_q.push_back(a);
          ov_q.push_back(cyc);
        end
        if (bus.out_valid && bus.out_ready) begin
          check("word_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_word", bus.out_word, e.word);
            check("out_last", bus.out_last, e.last);
          end
          words_seen++;
          if (bus.out_last) expect_idle = 1'b1;
        end
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_last  = bus.out_last;
        prev_word  = bus.out_word;
        prev_data  = bus.out_data;
      end
    end
  end

  // Holds the request until it is accepted; returns the acceptance cycle.
  task automatic do_req(input int idx, input int word, output int acc);
    bus.req_valid = 1'b1;
    bus.req_index = IW'(idx);
    bus.req_word  = WB'(word);
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !bus.out_valid && bus.req_ready) begin
        done = 1'b1;
        break;
      end
    end
    check("stream_done", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int            acc;
    int            acc9;
    int            base;
    int            accs[4];
    logic [DW-1:0] orig5;
    total         = 0;
    bad           = 0;
    words_seen    = 0;
    bp            = 1'b0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.req_word  = '0;
    for (int i = 0; i < 512; i++)
      for (int w = 0; w < NW; w++) mem[i][SW*w +: SW] = $urandom();
    for (int w = 0; w < NW; w++) mem[5][SW*w +: SW] = 32'h11111111 * w;

    // Reset state.
    #12;
    check("reset_outputs",
          {bus.req_ready, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.out_word, bus.out_last},
          {1'b1, 1'b0, 9'd0, 1'b0, 32'd0, 3'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic stream from word 0.
    base = words_seen;
    do_req(5, 0, acc);
    wait_done();
    check("basic_count", words_seen - base, NW);

    // Critical-word wrap.
    base = words_seen;
    do_req(5, 6, acc);
    wait_done();
    check("wrap_count", words_seen - base, NW);

    // Random back-pressure.
    base = words_seen;
    bp   = 1'b1;
    do_req(5, 3, acc);
    wait_done();
    bp = 1'b0;
    check("bp_count", words_seen - base, NW);

    // Request blocking and buffer isolation.
    base  = words_seen;
    orig5 = mem[5];
    do_req(5, 1, acc);
    fork
      do_req(9, 2, acc9);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        @(posedge clk);
        #1;
        mem[5] = ~orig5;
      end
    join
    check("blocked_accept_cycle", acc9, acc + 11);
    wait_done();
    mem[5] = orig5;
    check("block_count", words_seen - base, 2 * NW);

    // Reset after the third handshake.
    base = words_seen;
    do_req(5, 1, acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (words_seen >= base + 3) break;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.req_ready, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.out_word, bus.out_last},
          {1'b1, 1'b0, 9'd0, 1'b0, 32'd0, 3'd0, 1'b0});
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", {bus.req_ready, bus.out_valid}, 2'b10);
    repeat (4) @(negedge clk);
    check("no_stale_words", words_seen - base, 3);
    @(posedge clk);
    #1;
    base = words_seen;
    do_req(5, 4, acc);
    wait_done();
    check("post_reset_count", words_seen - base, NW);

    // Back-to-back random requests.
    base = words_seen;
    for (int i = 0; i < 4; i++) begin
      do_req(int'($urandom_range(0, 511)), int'($urandom_range(0, 7)), accs[i]);
      if (i > 0) check("b2b_spacing", accs[i] - accs[i-1], 11);
    end
    wait_done();
    check("b2b_count", words_seen - base, 4 * NW);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
